// File: rtl/regfile_dumper.sv
// Sequential readout engine: walks a register file's async read port and streams
// each register, tagged with its address, over a valid/ready interface.
module regfile_dumper #(
    parameter int N_REG_ADDR = 5,
    parameter int N_DATA     = 32,
    parameter int SKIP_X0    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [N_REG_ADDR-1:0] rf_addr,
    input  logic [N_DATA-1:0]     rf_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_REG_ADDR-1:0] out_addr,
    output logic [N_DATA-1:0]     out_data,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [N_REG_ADDR-1:0] LAST_IDX  = '1;
    localparam logic [N_REG_ADDR-1:0] FIRST_IDX = (SKIP_X0 != 0) ? N_REG_ADDR'(1) : '0;

    state_t                  state_q, state_d;
    logic [N_REG_ADDR-1:0]   idx_q, idx_d;
    logic [N_REG_ADDR-1:0]   out_addr_q, out_addr_d;
    logic [N_DATA-1:0]       out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = FIRST_IDX;
                    state_d = READ;
                end
            end
            READ: begin
                out_data_d  = rf_read_data;
                out_addr_d  = idx_q;
                out_last_d  = (idx_q == LAST_IDX);
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    // The last word never increments idx, so the counter cannot wrap.
                    if (out_last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign rf_addr   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper: instance 0 dumps all registers, instance 1
// skips x0; a behavioural register file with async read sits beside both.
module tb_regfile_dumper;

    logic        clk;
    logic        rst;
    logic        start_w     [2];
    logic        out_ready_w [2];
    logic        busy_w      [2];
    logic        done_w      [2];
    logic [4:0]  rf_addr_w   [2];
    logic [31:0] rd_w        [2];
    logic        out_valid_w [2];
    logic [4:0]  out_addr_w  [2];
    logic [31:0] out_data_w  [2];
    logic        out_last_w  [2];

    logic [31:0] rf      [32];
    logic [31:0] exp_mem [32];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        assign rd_w[gi] = rf[rf_addr_w[gi]];
        regfile_dumper #(
            .N_REG_ADDR (5),
            .N_DATA     (32),
            .SKIP_X0    (gi)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start_w[gi]),
            .busy         (busy_w[gi]),
            .done         (done_w[gi]),
            .rf_addr      (rf_addr_w[gi]),
            .rf_read_data (rd_w[gi]),
            .out_valid    (out_valid_w[gi]),
            .out_ready    (out_ready_w[gi]),
            .out_addr     (out_addr_w[gi]),
            .out_data     (out_data_w[gi]),
            .out_last     (out_last_w[gi])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input int s, input string tag);
        chk({tag, "_busy"},      {31'd0, busy_w[s]},      32'd0);
        chk({tag, "_done"},      {31'd0, done_w[s]},      32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid_w[s]}, 32'd0);
        chk({tag, "_out_last"},  {31'd0, out_last_w[s]},  32'd0);
        chk({tag, "_out_addr"},  {27'd0, out_addr_w[s]},  32'd0);
        chk({tag, "_out_data"},  out_data_w[s],           32'd0);
        chk({tag, "_rf_addr"},   {27'd0, rf_addr_w[s]},   32'd0);
    endtask

    // One dump on instance s. bp: random out_ready; ign_at/rst_at: word count at
    // which to re-pulse start / assert reset (-1 = never); live: write x7 and x2 mid-dump.
    task automatic run_dump(input int s, input bit bp, input int ign_at,
                            input int rst_at, input bit live);
        int          expi      = s;
        int          nw        = 32 - s;
        int          words     = 0;
        int          stalls    = 0;
        bit          prev_stall = 0;
        bit          done_seen = 0;
        bit          ign_done  = 0;
        bit          live_done = 0;
        bit          in_reset  = 0;
        int          quiet     = 0;
        bit          rdy;
        logic [31:0] pd = '0;
        logic [4:0]  pa = '0;
        logic        pl = 1'b0;

        start_w[s] = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            start_w[s] = 1'b0;

            if (in_reset) begin
                if (quiet == 0) begin
                    chk_reset_outputs(s, "abort");
                    rst = 1'b0;
                end else begin
                    chk("abort_no_done", {31'd0, done_w[s]}, 32'd0);
                    chk("abort_idle",    {31'd0, busy_w[s]}, 32'd0);
                end
                quiet++;
                if (quiet == 5) begin
                    $display("dump s=%0d aborted after %0d words", s, words);
                    return;
                end
                continue;
            end

            if (done_seen) begin
                chk("done_one_cycle", {31'd0, done_w[s]}, 32'd0);
                chk("busy_after_done", {31'd0, busy_w[s]}, 32'd0);
                $display("dump s=%0d words=%0d stalls=%0d", s, words, stalls);
                return;
            end

            if (cyc == 0) begin
                chk("busy_after_start", {31'd0, busy_w[s]}, 32'd1);
                chk("no_valid_in_read", {31'd0, out_valid_w[s]}, 32'd0);
            end

            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid_w[s]}, 32'd1);
                chk("stall_data",  out_data_w[s],           pd);
                chk("stall_addr",  {27'd0, out_addr_w[s]},  {27'd0, pa});
                chk("stall_last",  {31'd0, out_last_w[s]},  {31'd0, pl});
            end

            if (done_w[s]) begin
                done_seen = 1;
                chk("done_cycle", cyc, 2 * nw + stalls);
                chk("word_count", words, nw);
                chk("busy_in_done", {31'd0, busy_w[s]}, 32'd1);
            end

            if (ign_at >= 0 && words == ign_at && !ign_done) begin
                ign_done   = 1;
                start_w[s] = 1'b1;
            end
            if (live && words == 5 && !live_done) begin
                live_done  = 1;
                rf[7]      = 32'h1234_5678;
                exp_mem[7] = 32'h1234_5678;
                rf[2]      = 32'hDEAD_BEEF;
            end

            if (out_valid_w[s]) begin
                rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                out_ready_w[s] = rdy;
                if (rdy) begin
                    chk("word_addr", {27'd0, out_addr_w[s]}, expi);
                    chk("word_data", out_data_w[s], exp_mem[expi]);
                    chk("word_last", {31'd0, out_last_w[s]}, (expi == 31) ? 32'd1 : 32'd0);
                    expi++;
                    words++;
                    prev_stall = 0;
                end else begin
                    stalls++;
                    prev_stall = 1;
                    pd = out_data_w[s];
                    pa = out_addr_w[s];
                    pl = out_last_w[s];
                end
            end else begin
                out_ready_w[s] = bp ? 1'($urandom_range(0, 1)) : 1'b0;
                prev_stall = 0;
            end

            if (rst_at >= 0 && words == rst_at) begin
                rst      = 1'b1;
                in_reset = 1;
            end
        end
        chk("dump_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start_w[s]     = 1'b0;
            out_ready_w[s] = 1'b0;
        end
        rf[0]      = 32'd0;
        exp_mem[0] = 32'd0;
        for (int i = 1; i < 32; i++) begin
            rf[i]      = 32'hA500_0000 + 32'(i);
            exp_mem[i] = 32'hA500_0000 + 32'(i);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_busy0",  {31'd0, busy_w[0]},      32'd0);
            chk("idle_valid0", {31'd0, out_valid_w[0]}, 32'd0);
        end
        chk_reset_outputs(0, "reset0");
        chk_reset_outputs(1, "reset1");

        run_dump(0, 1'b0, -1, -1, 1'b0);
        run_dump(0, 1'b1, -1, -1, 1'b0);
        run_dump(1, 1'b0, -1, -1, 1'b0);
        run_dump(0, 1'b0, 5, 10, 1'b0);
        run_dump(0, 1'b0, -1, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
